gpio_apb_arbiter: RTL

Two-requester APB master that shares the single GPIO APB slave port between two on-chip requesters, for example the core load/store path and a DMA or debug path. It accepts one request at a time from each side, arbitrates round-robin, and runs a standard two-phase APB transfer (SETUP, then ACCESS). On completion it returns read data and a one-cycle done pulse to the winning requester. A PREADY timeout guarantees forward progress if the slave never responds.

---
 rtl/gpio_apb_arbiter.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/gpio_apb_arbiter.sv
// ---------------------------------------------------------------------------
// gpio_apb_arbiter
//
// Shares one APB slave port (the GPIO block) between two on-chip requesters.
// Each requester presents one request at a time. When both are pending, a
// round-robin pointer picks the winner. The block then runs a standard
// two-phase APB transfer (SETUP, then ACCESS). When the transfer ends, the
// winner gets a one-cycle ready pulse together with its read data. If the
// slave holds PREADY low for too long, the transfer is aborted with err = 1.
//
// Handshake contract (requester side):
//   reqN_valid is raised with reqN_write/addr/wdata/strb stable and held until
//   the cycle in which reqN_ready pulses. The fields are sampled only at the
//   grant edge. reqN_err and reqN_rdata are meaningful in the reqN_ready
//   cycle. reqN_rdata then holds until the next completion to that requester.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   req{0,1}_valid/write/addr/wdata/strb   request inputs
//   req{0,1}_ready/err/rdata     completion outputs (registered)
//   Paddr, Pwdata, Pstrb, Pwrite, Psel, Penable   APB master outputs (registered)
//   Prdata, Pready               APB slave response
//   dbg_state                    current FSM state (0 IDLE, 1 SETUP, 2 ACCESS)
//
// Parameter:
//   TIMEOUT  ACCESS cycles without Pready before abort (1..255)
// ---------------------------------------------------------------------------
module gpio_apb_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        reset,

   input  logic        req0_valid,
   input  logic        req0_write,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_wdata,
   input  logic [3:0]  req0_strb,
   output logic        req0_ready,
   output logic        req0_err,
   output logic [31:0] req0_rdata,

   input  logic        req1_valid,
   input  logic        req1_write,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_wdata,
   input  logic [3:0]  req1_strb,
   output logic        req1_ready,
   output logic        req1_err,
   output logic [31:0] req1_rdata,

   output logic [31:0] Paddr,
   output logic [31:0] Pwdata,
   output logic [3:0]  Pstrb,
   output logic        Pwrite,
   output logic        Psel,
   output logic        Penable,
   input  logic [31:0] Prdata,
   input  logic        Pready,

   output logic [1:0]  dbg_state
);

   localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t      state_q;
   logic        last_grant_q;   // index of the requester served last
   logic        gnt_q;          // index of the requester in flight
   logic [7:0]  wait_cnt_q;

   logic [31:0] paddr_q;
   logic [31:0] pwdata_q;
   logic [3:0]  pstrb_q;
   logic        pwrite_q;
   logic        psel_q;
   logic        penable_q;

   logic        req0_ready_q;
   logic        req0_err_q;
   logic [31:0] req0_rdata_q;
   logic        req1_ready_q;
   logic        req1_err_q;
   logic [31:0] req1_rdata_q;

   // Arbitration decision and the winner's request fields.
   logic        elig0_d;
   logic        elig1_d;
   logic        grant_any_d;
   logic        grant_idx_d;
   logic [31:0] win_addr_d;
   logic [31:0] win_wdata_d;
   logic [3:0]  win_strb_d;
   logic        win_write_d;
   logic        timeout_hit_d;

   always_comb begin
      // A requester whose ready pulse is high this cycle is still holding
      // valid for the request that just completed, so it must not be
      // re-granted on the same edge.
      elig0_d     = req0_valid & ~req0_ready_q;
      elig1_d     = req1_valid & ~req1_ready_q;
      grant_any_d = elig0_d | elig1_d;

      // Tie goes to the requester that was not served last. Otherwise the
      // single eligible requester wins.
      if (elig0_d && elig1_d) begin
         grant_idx_d = ~last_grant_q;
      end else begin
         grant_idx_d = elig1_d;
      end

      win_addr_d  = grant_idx_d ? req1_addr  : req0_addr;
      win_wdata_d = grant_idx_d ? req1_wdata : req0_wdata;
      win_strb_d  = grant_idx_d ? req1_strb  : req0_strb;
      win_write_d = grant_idx_d ? req1_write : req0_write;

      // Pready takes priority over the timeout in the same cycle, so this
      // term only matters when Pready is low.
      timeout_hit_d = (wait_cnt_q == TIMEOUT_CNT);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;   // req0 wins the first tie
         gnt_q        <= 1'b0;
         wait_cnt_q   <= 8'd0;
         paddr_q      <= 32'd0;
         pwdata_q     <= 32'd0;
         pstrb_q      <= 4'd0;
         pwrite_q     <= 1'b0;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         req0_ready_q <= 1'b0;
         req0_err_q   <= 1'b0;
         req0_rdata_q <= 32'd0;
         req1_ready_q <= 1'b0;
         req1_err_q   <= 1'b0;
         req1_rdata_q <= 32'd0;
      end else begin
         // Ready and err are single-cycle pulses.
         req0_ready_q <= 1'b0;
         req0_err_q   <= 1'b0;
         req1_ready_q <= 1'b0;
         req1_err_q   <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (grant_any_d) begin
                  paddr_q    <= win_addr_d;
                  pwdata_q   <= win_wdata_d;
                  pstrb_q    <= win_strb_d;
                  pwrite_q   <= win_write_d;
                  gnt_q      <= grant_idx_d;
                  wait_cnt_q <= 8'd0;
                  psel_q     <= 1'b1;
                  penable_q  <= 1'b0;
                  state_q    <= ST_SETUP;
               end
            end

            ST_SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ST_ACCESS;
            end

            ST_ACCESS: begin
               if (Pready) begin
                  if (gnt_q) begin
                     req1_ready_q <= 1'b1;
                     if (!pwrite_q) begin
                        req1_rdata_q <= Prdata;
                     end
                  end else begin
                     req0_ready_q <= 1'b1;
                     if (!pwrite_q) begin
                        req0_rdata_q <= Prdata;
                     end
                  end
                  last_grant_q <= gnt_q;
                  psel_q       <= 1'b0;
                  penable_q    <= 1'b0;
                  state_q      <= ST_IDLE;
               end else if (timeout_hit_d) begin
                  // Slave never answered: abort with err and zero data.
                  if (gnt_q) begin
                     req1_ready_q <= 1'b1;
                     req1_err_q   <= 1'b1;
                     req1_rdata_q <= 32'd0;
                  end else begin
                     req0_ready_q <= 1'b1;
                     req0_err_q   <= 1'b1;
                     req0_rdata_q <= 32'd0;
                  end
                  last_grant_q <= gnt_q;
                  psel_q       <= 1'b0;
                  penable_q    <= 1'b0;
                  state_q      <= ST_IDLE;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 8'd1;
               end
            end

            default: begin
               psel_q    <= 1'b0;
               penable_q <= 1'b0;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   assign Paddr      = paddr_q;
   assign Pwdata     = pwdata_q;
   assign Pstrb      = pstrb_q;
   assign Pwrite     = pwrite_q;
   assign Psel       = psel_q;
   assign Penable    = penable_q;

   assign req0_ready = req0_ready_q;
   assign req0_err   = req0_err_q;
   assign req0_rdata = req0_rdata_q;
   assign req1_ready = req1_ready_q;
   assign req1_err   = req1_err_q;
   assign req1_rdata = req1_rdata_q;

   assign dbg_state  = state_q;

endmodule
